window_buffer_kxk: RTL and testbench
====================================

# window_buffer_kxk

Parametrised K×K sliding-window register array, replacing the fixed 13×13 window buffers. It accepts one K-pixel column per valid cycle from the line-buffer stage and shifts it into a K×K register window. It presents the window as one flat bus with a per-column valid strobe. An internal controller tracks row and column position, suppresses windows that would straddle a row boundary, and reports frame completion.

## Interface
- K, 13: window size; odd, 3..15.
- COLS, 11: pixel columns per row; COLS ≥ K.
- ROWS, 11: rows (column strobes per frame = ROWS×COLS).
- DATA_W, 8: bits per pixel.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  col_i is valid this cycle; one column is accepted per high cycle.
- col_i  in  K*DATA_W  lane j at [j*DATA_W +: DATA_W]; lane 0 = top row of window.
- abort_i  in  1  synchronous frame abort.
- win_o  out  K*K*DATA_W  element (r,c) at [(r*K+c)*DATA_W +: DATA_W]; c=0 oldest (leftmost), c=K-1 newest.
- valid_o  out  1  win_o holds a complete, row-aligned window.
- done_o  out  1  one-cycle pulse after the last column of a frame.
- progress_done_o  out  1  sticky frame-complete flag.

## Operation
- Counters:
  - col_cnt: $clog2(COLS) bits.
  - row_cnt: $clog2(ROWS) bits.
  - Both reset to 0 and advance only on an accepted column.
- Accepted column: valid_i=1 in state IDLE, ACTIVE or DONE, with abort_i=0.
- Window shift on accept:
  - element (r,c) ← element (r,c+1) for c<K-1.
  - element (r,K-1) ← lane r of col_i.
  - With no accept, the window holds.
- valid_o is registered: high for exactly one cycle after an accepted column whose col_cnt ≥ K-1 (before increment); low otherwise.
- Per row there are COLS-K+1 valid windows. Columns from the previous row never contribute to a valid window.
- Column wrap: on accept with col_cnt=COLS-1, col_cnt→0 and row_cnt increments. If row_cnt=ROWS-1 as well, row_cnt→0 and the frame ends.
- FSM:
  - IDLE → ACTIVE on the first accepted column. That column counts as (row 0, col 0) and clears progress_done_o.
  - ACTIVE → DONE on the accept of (ROWS-1, COLS-1). done_o is high during DONE (exactly one cycle), and progress_done_o is set the same cycle.
  - DONE → IDLE if valid_i=0. If valid_i=1, DONE → ACTIVE and the column is accepted as (0,0) of the next frame; this clears progress_done_o next cycle.
  - Any state → IDLE on abort_i=1:
    - counters → 0, valid_o → 0 next cycle, done_o not pulsed, progress_done_o unchanged.
    - Window contents are held.
    - abort_i has priority over a simultaneous valid_i.
- Window contents are never cleared except by reset. Stale data is masked by valid_o.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; col_cnt=0, row_cnt=0.
  - win_o all zero; valid_o=0, done_o=0, progress_done_o=0.
- Release is synchronous to clk. The first accept is possible on the first rising edge with rst=1.
- Latency: column accepted at edge n → win_o and valid_o updated at edge n and visible in cycle n+1.
- done_o: asserted in the cycle after the final accept, together with the final valid_o.
- Throughput: one column per cycle, with no bubbles required between rows or frames.
- Gaps: valid_i may drop for any number of cycles. Counters, window and FSM hold; valid_o=0 during gaps.
- Mid-frame reset: immediate return to reset values; no done_o.

## Test plan
- Stream (K=3, COLS=5, ROWS=4) with col_i lanes = {row*16+col} → valid_o high for columns 2..4 of each row (12 pulses). The window at (row 1, col 2) has top-left element 0x10 and bottom-right element 0x12 (lane pattern); done_o pulses once, after the 20th accept, and progress_done_o=1 thereafter.
- Same frame with valid_i toggled 1-0-1-0 → identical window sequence and count, valid_o never high in gap cycles, done_o delayed accordingly.
- Back-to-back frames, valid_i continuously high → done_o single pulse between frames, first column of frame 2 accepted in the DONE cycle, progress_done_o falls one cycle later, 24 total valid_o pulses.
- abort_i asserted at (row 2, col 3) with valid_i=1 → column not accepted, valid_o=0 next cycle, no done_o, next accept treated as (0,0).
- rst pulsed low for 1 cycle mid-row (asynchronously, between edges) → all outputs zero immediately, win_o all zero, FSM IDLE.
- K=13, COLS=13, ROWS=13 → exactly one valid_o per row (13 total), full 169-element window matches the reference model.

Source files
------------

// File: rtl/window_buffer_kxk_if.sv
// window_buffer_kxk_if
//   Bundles the column-in / window-out signals of the K x K sliding window.
//   master : the producer side (line-buffer stage or bench) that drives the
//            column stream and observes the window.
//   slave  : the window buffer itself.
//   Signals
//     valid_i          column strobe, one column accepted per high cycle
//     col_i            K lanes of DATA_W, lane 0 = top row of the window
//     abort_i          synchronous frame abort
//     win_o            K*K elements, element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//     valid_o          win_o holds a complete, row-aligned window
//     done_o           one-cycle pulse after the last column of a frame
//     progress_done_o  sticky frame-complete flag
interface window_buffer_kxk_if #(
  parameter int K      = 13,
  parameter int DATA_W = 8
);
  logic                      valid_i;
  logic [K*DATA_W-1:0]       col_i;
  logic                      abort_i;
  logic [K*K*DATA_W-1:0]     win_o;
  logic                      valid_o;
  logic                      done_o;
  logic                      progress_done_o;

  modport master (
    output valid_i, col_i, abort_i,
    input  win_o, valid_o, done_o, progress_done_o
  );

  modport slave (
    input  valid_i, col_i, abort_i,
    output win_o, valid_o, done_o, progress_done_o
  );
endinterface

// File: rtl/window_buffer_kxk.sv
// window_buffer_kxk
//   Parametrised K x K sliding-window register array. Each accepted column is
//   shifted in at the right edge (c = K-1) and the oldest column drops off the
//   left edge (c = 0). A row/column tracker flags windows that lie entirely
//   inside one row and reports frame completion.
//   Ports
//     clk  : sole clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : window_buffer_kxk_if slave modport (column in, window out)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no frame in progress; next accepted column is (row 0, col 0)
//   ACTIVE  | frame in progress
//   DONE    | last column of the frame was accepted last edge; done_o high
module window_buffer_kxk #(
  parameter int K      = 13,
  parameter int COLS   = 11,
  parameter int ROWS   = 11,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  window_buffer_kxk_if.slave bus
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WW = K * K * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [WW-1:0]   win_q, win_d;
  logic            valid_q, valid_d;
  logic            prog_q, prog_d;

  logic            accept;
  logic            col_last;
  logic            row_last;

  // Abort wins over a simultaneous column strobe; every state can accept.
  assign accept   = bus.valid_i && !bus.abort_i;
  assign col_last = (col_cnt_q == CW'(COLS - 1));
  assign row_last = (row_cnt_q == RW'(ROWS - 1));

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    win_d     = win_q;
    valid_d   = 1'b0;
    prog_d    = prog_q;

    if (bus.abort_i) begin
      // Window contents and the sticky flag are deliberately left untouched.
      state_d   = S_IDLE;
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[(r*K+c)*DATA_W +: DATA_W] = win_q[(r*K+c+1)*DATA_W +: DATA_W];
        end
        win_d[(r*K+K-1)*DATA_W +: DATA_W] = bus.col_i[r*DATA_W +: DATA_W];
      end

      // Only windows whose K columns all belong to the current row count.
      valid_d = (int'(col_cnt_q) >= K - 1);

      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end

      // From IDLE or DONE this column starts a new frame.
      if (state_q != S_ACTIVE) begin
        prog_d = 1'b0;
      end

      if (col_last && row_last) begin
        state_d = S_DONE;
        prog_d  = 1'b1;
      end else begin
        state_d = S_ACTIVE;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      prog_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      prog_q    <= prog_d;
    end
  end

  assign bus.win_o           = win_q;
  assign bus.valid_o         = valid_q;
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.progress_done_o = prog_q;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb_window_buffer_kxk
//   Drives a small 3x3 configuration (5 columns x 4 rows) through directed
//   frames, gaps, back-to-back frames, aborts and an asynchronous reset, then
//   streams a full 13x13 frame into a second instance and compares every
//   valid window against a shift-register reference.
module tb_window_buffer_kxk;

  localparam int KA = 3;
  localparam int CA = 5;
  localparam int RA = 4;
  localparam int KB = 13;
  localparam int CB = 13;
  localparam int RB = 13;
  localparam int DW = 8;
  localparam int WB = KB * KB * DW;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   vcount;

  window_buffer_kxk_if #(.K(KA), .DATA_W(DW)) ifa ();
  window_buffer_kxk_if #(.K(KB), .DATA_W(DW)) ifb ();

  window_buffer_kxk #(.K(KA), .COLS(CA), .ROWS(RA), .DATA_W(DW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  window_buffer_kxk #(.K(KB), .COLS(CB), .ROWS(RB), .DATA_W(DW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic       ed;
    logic       ep;
    logic [7:0] tl;
    logic [7:0] br;
  } vec_t;

  vec_t tab[20];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_a(input int i);
    return 8'(((i / CA) % RA) * 16 + (i % CA));
  endfunction

  task automatic step_a(input logic v, input logic ab, input logic [7:0] p);
    @(negedge clk);
    ifa.valid_i = v;
    ifa.abort_i = ab;
    ifa.col_i   = {KA{p}};
    @(posedge clk);
    #1;
    if (ifa.valid_o) vcount++;
  endtask

  function automatic logic [7:0] tl_a();
    return ifa.win_o[7:0];
  endfunction

  function automatic logic [7:0] br_a();
    return ifa.win_o[(2*KA+2)*DW +: DW];
  endfunction

  // Streams one full frame with a checked accept per column; gap cycles with
  // valid_i low are inserted after every column when gaps is set.
  task automatic frame_a(input string nm, input logic gaps);
    int c;
    vcount = 0;
    for (int i = 0; i < CA * RA; i++) begin
      c = i % CA;
      step_a(1'b1, 1'b0, pix_a(i));
      chk({nm, "_valid"}, 32'(ifa.valid_o), 32'(c >= KA - 1));
      chk({nm, "_done"},  32'(ifa.done_o),  32'(i == CA * RA - 1));
      chk({nm, "_prog"},  32'(ifa.progress_done_o), 32'(i == CA * RA - 1));
      chk({nm, "_br"},    32'(br_a()), 32'(pix_a(i)));
      if (gaps) begin
        step_a(1'b0, 1'b0, 8'hFF);
        chk({nm, "_gap_valid"}, 32'(ifa.valid_o), 32'd0);
        chk({nm, "_gap_done"},  32'(ifa.done_o),  32'd0);
        chk({nm, "_gap_br"},    32'(br_a()), 32'(pix_a(i)));
      end
    end
    chk({nm, "_pulses"}, 32'(vcount), 32'd12);
  endtask

  logic [7:0]    ref_w [KB][KB];
  logic [WB-1:0] exp_w;
  int            r;
  int            c;

  initial begin
    checks = 0;
    errors = 0;
    vcount = 0;

    // Lane values are equal across lanes; tl = element (0,0), br = element (2,2).
    tab[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tab[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
    tab[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h03};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h04};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 8'h03, 8'h10};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h11};
    tab[7]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h12};
    tab[8]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h13};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h14};
    tab[10] = '{1'b0, 1'b0, 1'b0, 8'h13, 8'h20};
    tab[11] = '{1'b0, 1'b0, 1'b0, 8'h14, 8'h21};
    tab[12] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h22};
    tab[13] = '{1'b1, 1'b0, 1'b0, 8'h21, 8'h23};
    tab[14] = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h24};
    tab[15] = '{1'b0, 1'b0, 1'b0, 8'h23, 8'h30};
    tab[16] = '{1'b0, 1'b0, 1'b0, 8'h24, 8'h31};
    tab[17] = '{1'b1, 1'b0, 1'b0, 8'h30, 8'h32};
    tab[18] = '{1'b1, 1'b0, 1'b0, 8'h31, 8'h33};
    tab[19] = '{1'b1, 1'b1, 1'b1, 8'h32, 8'h34};

    rst         = 1'b0;
    ifa.valid_i = 1'b0;
    ifa.abort_i = 1'b0;
    ifa.col_i   = '0;
    ifb.valid_i = 1'b0;
    ifb.abort_i = 1'b0;
    ifb.col_i   = '0;

    #2;
    chk("rst_valid", 32'(ifa.valid_o), 32'd0);
    chk("rst_done",  32'(ifa.done_o),  32'd0);
    chk("rst_prog",  32'(ifa.progress_done_o), 32'd0);
    chkw("rst_win",  WB'(ifa.win_o), '0);
    @(negedge clk);
    rst = 1'b1;

    // Continuous first frame, table driven.
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step_a(1'b1, 1'b0, pix_a(i));
      chk($sformatf("tab%0d_valid", i), 32'(ifa.valid_o), 32'(tab[i].ev));
      chk($sformatf("tab%0d_done", i),  32'(ifa.done_o),  32'(tab[i].ed));
      chk($sformatf("tab%0d_prog", i),  32'(ifa.progress_done_o), 32'(tab[i].ep));
      chk($sformatf("tab%0d_tl", i),    32'(tl_a()), 32'(tab[i].tl));
      chk($sformatf("tab%0d_br", i),    32'(br_a()), 32'(tab[i].br));
    end
    chk("tab_pulses", 32'(vcount), 32'd12);
    step_a(1'b0, 1'b0, 8'hFF);
    chk("post_frame_done", 32'(ifa.done_o), 32'd0);
    chk("post_frame_prog", 32'(ifa.progress_done_o), 32'd1);
    chk("post_frame_valid", 32'(ifa.valid_o), 32'd0);

    // Same frame with a gap after every column.
    frame_a("gap", 1'b1);

    // Two back-to-back frames with valid_i held high.
    vcount = 0;
    for (int i = 0; i < 2 * CA * RA; i++) begin
      c = i % CA;
      step_a(1'b1, 1'b0, pix_a(i));
      chk("b2b_valid", 32'(ifa.valid_o), 32'(c >= KA - 1));
      chk("b2b_done",  32'(ifa.done_o),  32'((i % 20) == 19));
      chk("b2b_prog",  32'(ifa.progress_done_o), 32'(i == 19 || i == 39));
      chk("b2b_br",    32'(br_a()), 32'(pix_a(i)));
    end
    chk("b2b_pulses", 32'(vcount), 32'd24);

    // Abort with valid_i high in the DONE cycle: sticky flag must survive.
    step_a(1'b1, 1'b1, 8'hEE);
    chk("abort_done_valid", 32'(ifa.valid_o), 32'd0);
    chk("abort_done_done",  32'(ifa.done_o),  32'd0);
    chk("abort_done_prog",  32'(ifa.progress_done_o), 32'd1);
    chk("abort_done_br",    32'(br_a()), 32'h34);

    // Abort at (row 2, col 3).
    for (int i = 0; i < 13; i++) step_a(1'b1, 1'b0, pix_a(i));
    chk("pre_abort_valid", 32'(ifa.valid_o), 32'd1);
    step_a(1'b1, 1'b1, pix_a(13));
    chk("abort_valid", 32'(ifa.valid_o), 32'd0);
    chk("abort_done",  32'(ifa.done_o),  32'd0);
    chk("abort_prog",  32'(ifa.progress_done_o), 32'd0);
    chk("abort_br",    32'(br_a()), 32'h22);
    chk("abort_tl",    32'(tl_a()), 32'h20);
    frame_a("after_abort", 1'b0);

    // Asynchronous reset between edges, right after a valid window.
    for (int i = 0; i < 8; i++) step_a(1'b1, 1'b0, pix_a(i));
    chk("pre_rst_valid", 32'(ifa.valid_o), 32'd1);
    step_a(1'b0, 1'b0, 8'hFF);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(ifa.valid_o), 32'd0);
    chk("arst_done",  32'(ifa.done_o),  32'd0);
    chk("arst_prog",  32'(ifa.progress_done_o), 32'd0);
    chkw("arst_win",  WB'(ifa.win_o), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    frame_a("after_rst", 1'b0);

    ifa.valid_i = 1'b0;

    // 13x13 full-window check against a reference shift register.
    for (int rr = 0; rr < KB; rr++)
      for (int cc = 0; cc < KB; cc++) ref_w[rr][cc] = 8'h00;
    vcount = 0;
    for (int i = 0; i < CB * RB; i++) begin
      r = i / CB;
      c = i % CB;
      @(negedge clk);
      ifb.valid_i = 1'b1;
      ifb.abort_i = 1'b0;
      for (int l = 0; l < KB; l++) begin
        ifb.col_i[l*DW +: DW] = 8'(r * 16 + c + l * 17);
        for (int cc = 0; cc < KB - 1; cc++) ref_w[l][cc] = ref_w[l][cc+1];
        ref_w[l][KB-1] = 8'(r * 16 + c + l * 17);
      end
      @(posedge clk);
      #1;
      chk("k13_valid", 32'(ifb.valid_o), 32'(c == KB - 1));
      chk("k13_done",  32'(ifb.done_o),  32'(i == CB * RB - 1));
      if (ifb.valid_o) begin
        vcount++;
        for (int rr = 0; rr < KB; rr++)
          for (int cc = 0; cc < KB; cc++) exp_w[(rr*KB+cc)*DW +: DW] = ref_w[rr][cc];
        chkw("k13_win", ifb.win_o, exp_w);
      end
    end
    chk("k13_pulses", 32'(vcount), 32'd13);
    chk("k13_prog", 32'(ifb.progress_done_o), 32'd1);
    @(negedge clk);
    ifb.valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
